// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   NB_STATE        width of the receiver state encoding
//   ST_*            receiver FSM state encodings
//   OVERSAMPLE_DEF  default number of baud ticks per bit
//   parity_expected expected parity bit from the running data XOR
package uart_pkg;

  localparam int unsigned NB_STATE       = 3;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  localparam logic [NB_STATE-1:0] ST_IDLE   = 3'd0;
  localparam logic [NB_STATE-1:0] ST_START  = 3'd1;
  localparam logic [NB_STATE-1:0] ST_DATA   = 3'd2;
  localparam logic [NB_STATE-1:0] ST_PARITY = 3'd3;
  localparam logic [NB_STATE-1:0] ST_STOP   = 3'd4;

  // Even parity: the parity bit equals XOR(data); odd parity inverts it.
  function automatic logic parity_expected(input logic data_xor, input logic odd);
    return data_xor ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Per-bit timing and 3-sample majority vote.
//   i_clock, i_reset  clock and synchronous active-high reset
//   tick              baud-tick enable; everything advances only on a tick
//   clear             restart the bit timer (start edge accepted)
//   rx_sync           synchronised serial line
//   bit_c             majority of the samples at MID-1, MID and the live line
//   bit_done_c        tick on which the bit value is decided (timer == MID+1)
//   bit_end_c         tick on which the bit period ends (timer == OVERSAMPLE-1)
module uart_rx_bit_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned NB_TIMER   = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic tick,
  input  logic clear,
  input  logic rx_sync,
  output logic bit_c,
  output logic bit_done_c,
  output logic bit_end_c
);

  localparam int unsigned MID = OVERSAMPLE / 2;
  localparam logic [NB_TIMER-1:0] T_PRE = NB_TIMER'(MID - 1);
  localparam logic [NB_TIMER-1:0] T_MID = NB_TIMER'(MID);
  localparam logic [NB_TIMER-1:0] T_DEC = NB_TIMER'(MID + 1);
  localparam logic [NB_TIMER-1:0] T_END = NB_TIMER'(OVERSAMPLE - 1);

  logic [NB_TIMER-1:0] timer;
  logic                s_pre;
  logic                s_mid;

  // Bit timer and the two early mid-bit samples
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      timer <= '0;
      s_pre <= 1'b1;
      s_mid <= 1'b1;
    end else if (tick) begin
      if (clear || (timer == T_END)) timer <= '0;
      else                           timer <= timer + NB_TIMER'(1);
      if (timer == T_PRE) s_pre <= rx_sync;
      if (timer == T_MID) s_mid <= rx_sync;
    end
  end

  // Third sample is the live line at MID+1, so the vote is ready on that tick
  assign bit_c      = (s_pre & s_mid) | (s_pre & rx_sync) | (s_mid & rx_sync);
  assign bit_done_c = tick & (timer == T_DEC);
  assign bit_end_c  = tick & (timer == T_END);

endmodule

// File: rtl/uart_rx_mv.sv
// UART receiver with runtime frame format, majority-vote sampling, false-start
// rejection, per-frame error flags and a single-entry valid/ready output.
//   i_clock, i_reset      clock and synchronous active-high reset
//   i_valid               baud tick (OVERSAMPLE per bit)
//   i_rx                  asynchronous serial line, idle high
//   i_cfg_*               frame format, captured when a start edge is accepted
//   o_data                received word, right-aligned
//   o_data_valid          holding register full; i_data_ready consumes it
//   o_parity_err, o_frame_err, o_break  qualify o_data
//   o_overrun             one-clock pulse when a finished frame is dropped
module uart_rx_mv
  import uart_pkg::*;
#(
  parameter int unsigned N_DATA_MAX = 8,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned NB_TIMER   = 4,
  parameter int unsigned NB_NBITS   = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_rx,
  input  logic [NB_NBITS-1:0]   i_cfg_nbits,
  input  logic                  i_cfg_par_en,
  input  logic                  i_cfg_par_odd,
  input  logic                  i_cfg_two_stop,
  output logic [N_DATA_MAX-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_overrun
);

  localparam logic [NB_NBITS-1:0] NBITS_MIN = NB_NBITS'(5);
  localparam logic [NB_NBITS-1:0] NBITS_MAX = NB_NBITS'(N_DATA_MAX);

  logic                  rx_meta, rx_sync, rx_prev;
  logic [NB_STATE-1:0]   state, state_d;
  logic [NB_NBITS-1:0]   nbits_q, bit_cnt;
  logic                  par_en_q, par_odd_q, two_stop_q;
  logic [N_DATA_MAX-1:0] shift_q;
  logic                  par_acc, par_err_q, frame_err_q, brk_q, stop_cnt;
  logic                  bit_c, bit_done_c, bit_end_c;
  logic                  fall_c, deliver_c, frame_err_c, brk_c, brk_final_c;
  logic [NB_NBITS-1:0]   cfg_nbits_c;
  logic [N_DATA_MAX-1:0] data_c;

  // Two-flop synchroniser, preset high so reset never looks like a start edge
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  assign fall_c      = i_valid & (state == ST_IDLE) & rx_prev & ~rx_sync;
  assign cfg_nbits_c = ((i_cfg_nbits < NBITS_MIN) || (i_cfg_nbits > NBITS_MAX))
                       ? NBITS_MAX : i_cfg_nbits;
  assign frame_err_c = frame_err_q | ~bit_c;
  assign brk_c       = (shift_q == '0) & ~bit_c;
  assign brk_final_c = two_stop_q ? brk_q : brk_c;
  // Bits arrive at the MSB end; short words need shifting down to bit 0
  assign data_c      = shift_q >> (NBITS_MAX - nbits_q);

  uart_rx_bit_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .NB_TIMER   (NB_TIMER)
  ) u_sampler (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .tick       (i_valid),
    .clear      (fall_c),
    .rx_sync    (rx_sync),
    .bit_c      (bit_c),
    .bit_done_c (bit_done_c),
    .bit_end_c  (bit_end_c)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_d;
  end

  // Next state and delivery strobe
  always_comb begin
    state_d   = state;
    deliver_c = 1'b0;
    case (state)
      ST_IDLE:   if (fall_c) state_d = ST_START;
      ST_START: begin
        if (bit_done_c && bit_c) state_d = ST_IDLE;
        else if (bit_end_c)      state_d = ST_DATA;
      end
      ST_DATA:   if (bit_end_c && (bit_cnt == nbits_q))
                   state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end_c) state_d = ST_STOP;
      ST_STOP: begin
        // Leave at mid last stop bit so the next start edge has half a bit of margin
        if (bit_done_c && (stop_cnt == two_stop_q)) begin
          deliver_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Frame datapath, holding register and handshake
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_prev      <= 1'b1;
      nbits_q      <= NBITS_MAX;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      shift_q      <= '0;
      par_acc      <= 1'b0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      brk_q        <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (i_valid) rx_prev <= rx_sync;

      if (fall_c) begin
        nbits_q     <= cfg_nbits_c;
        par_en_q    <= i_cfg_par_en;
        par_odd_q   <= i_cfg_par_odd;
        two_stop_q  <= i_cfg_two_stop;
        bit_cnt     <= '0;
        stop_cnt    <= 1'b0;
        shift_q     <= '0;
        par_acc     <= 1'b0;
        par_err_q   <= 1'b0;
        frame_err_q <= 1'b0;
        brk_q       <= 1'b0;
      end

      if ((state == ST_DATA) && bit_done_c) begin
        shift_q <= {bit_c, shift_q[N_DATA_MAX-1:1]};
        par_acc <= par_acc ^ bit_c;
        bit_cnt <= bit_cnt + NB_NBITS'(1);
      end

      if ((state == ST_PARITY) && bit_done_c)
        par_err_q <= bit_c ^ parity_expected(par_acc, par_odd_q);

      if ((state == ST_STOP) && bit_done_c) begin
        if (!bit_c)    frame_err_q <= 1'b1;
        if (!stop_cnt) brk_q       <= brk_c;
      end
      if ((state == ST_STOP) && bit_end_c) stop_cnt <= 1'b1;

      if (o_data_valid && i_data_ready) o_data_valid <= 1'b0;

      // A slot freed in this same cycle may be refilled immediately
      if (deliver_c) begin
        if (!o_data_valid || i_data_ready) begin
          o_data       <= data_c;
          o_parity_err <= par_err_q;
          o_frame_err  <= frame_err_c;
          o_break      <= brk_final_c;
          o_data_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mv.sv
// Directed bench for uart_rx_mv: expected words are queued as frames are sent
// and checked when the receiver hands them over.
module tb_uart_rx_mv;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       frm;
    logic       brk;
  } exp_t;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_rx = 1'b1;
  logic [3:0] i_cfg_nbits = 4'd8;
  logic       i_cfg_par_en = 1'b0;
  logic       i_cfg_par_odd = 1'b0;
  logic       i_cfg_two_stop = 1'b0;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       i_data_ready = 1'b1;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_break;
  logic       o_overrun;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ovr_cnt = 0;
  exp_t q[$];
  exp_t mon_e;

  uart_rx_mv dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .i_rx           (i_rx),
    .i_cfg_nbits    (i_cfg_nbits),
    .i_cfg_par_en   (i_cfg_par_en),
    .i_cfg_par_odd  (i_cfg_par_odd),
    .i_cfg_two_stop (i_cfg_two_stop),
    .o_data         (o_data),
    .o_data_valid   (o_data_valid),
    .i_data_ready   (i_data_ready),
    .o_parity_err   (o_parity_err),
    .o_frame_err    (o_frame_err),
    .o_break        (o_break),
    .o_overrun      (o_overrun)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic p, input logic f, input logic b);
    return {d, p, f, b};
  endfunction

  // Scoreboard: every accepted word must match the oldest queued expectation
  always @(negedge i_clock) begin
    if (!i_reset && (o_overrun === 1'b1)) ovr_cnt++;
    if (!i_reset && (o_data_valid === 1'b1) && (i_data_ready === 1'b1)) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(o_data_valid), 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("rx_word", 32'({o_data, o_parity_err, o_frame_err, o_break}), 32'(mon_e));
      end
    end
  end

  // One baud tick: i_valid high for one clock, then low for one
  task automatic tick(input logic v);
    @(negedge i_clock);
    i_valid = 1'b1;
    i_rx    = v;
    @(negedge i_clock);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic [3:0] cfgn,
                            input logic pen, input logic podd, input logic two,
                            input logic bad_par, input logic glitch, input logic chk_t);
    logic       b[$];
    logic [7:0] m;
    logic       bv;
    i_cfg_nbits    = cfgn;
    i_cfg_par_en   = pen;
    i_cfg_par_odd  = podd;
    i_cfg_two_stop = two;
    m = 8'((1 << nb) - 1);
    b.push_back(1'b0);
    for (int i = 0; i < nb; i++) b.push_back(d[i]);
    if (pen) b.push_back((^(d & m)) ^ podd ^ bad_par);
    b.push_back(1'b1);
    if (two) b.push_back(1'b1);
    for (int k = 0; k < b.size(); k++) begin
      for (int t = 0; t < 16; t++) begin
        bv = (glitch && (t == 9)) ? ~b[k] : b[k];
        tick(bv);
        if (chk_t && (k == b.size() - 1)) begin
          if (t == 10) chk("early_deliver", 32'(o_data_valid), 32'd0);
          if (t == 11) chk("deliver_mid_stop", 32'(o_data_valid), 32'd1);
        end
      end
    end
  endtask

  initial begin
    repeat (4) @(negedge i_clock);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_valid", 32'(o_data_valid), 32'd0);
    chk("rst_par", 32'(o_parity_err), 32'd0);
    chk("rst_frame", 32'(o_frame_err), 32'd0);
    chk("rst_break", 32'(o_break), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    i_reset = 1'b0;
    idle(4);

    // 8N1 0xA5 with delivery timing
    q.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
    send_frame(8'hA5, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);

    // 7E2 0x35 with inverted parity bit
    q.push_back(mk(8'h35, 1'b1, 1'b0, 1'b0));
    send_frame(8'h35, 7, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);

    // 5O1 0x1B, correct parity, short word alignment
    q.push_back(mk(8'h1B, 1'b0, 1'b0, 1'b0));
    send_frame(8'h1B, 5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // 8N1 0x3C with the mid sample of every bit inverted
    q.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
    send_frame(8'h3C, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);

    // 4-tick low pulse is rejected, then a normal frame still lands
    for (int i = 0; i < 4; i++) tick(1'b0);
    idle(30);
    chk("false_start_valid", 32'(o_data_valid), 32'd0);
    q.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0));
    send_frame(8'hC3, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Out-of-range nbits clamps to 8
    q.push_back(mk(8'h81, 1'b0, 1'b0, 1'b0));
    send_frame(8'h81, 8, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Overrun: second frame dropped while the first is held
    @(posedge i_clock); #1 i_data_ready = 1'b0;
    q.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0));
    send_frame(8'h11, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_frame(8'h22, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("overrun_pulses", 32'(ovr_cnt), 32'd1);
    chk("held_valid", 32'(o_data_valid), 32'd1);
    chk("held_data", 32'(o_data), 32'h11);
    @(posedge i_clock); #1 i_data_ready = 1'b1;
    repeat (3) @(negedge i_clock);
    chk("valid_after_ready", 32'(o_data_valid), 32'd0);
    idle(4);

    // Break: line low for 12 bit times
    i_cfg_nbits = 4'd8; i_cfg_par_en = 1'b0; i_cfg_two_stop = 1'b0;
    q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 192; i++) tick(1'b0);
    idle(20);

    // Reset in the middle of a frame clears a held word and recovers
    @(posedge i_clock); #1 i_data_ready = 1'b0;
    send_frame(8'h5A, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("held_before_reset", 32'(o_data), 32'h5A);
    for (int i = 0; i < 48; i++) tick(1'b0);
    @(posedge i_clock); #1 i_reset = 1'b1; i_rx = 1'b1;
    repeat (3) @(negedge i_clock);
    chk("midreset_data", 32'(o_data), 32'd0);
    chk("midreset_valid", 32'(o_data_valid), 32'd0);
    chk("midreset_flags", 32'({o_parity_err, o_frame_err, o_break, o_overrun}), 32'd0);
    i_reset = 1'b0;
    i_data_ready = 1'b1;
    idle(4);
    q.push_back(mk(8'h96, 1'b0, 1'b0, 1'b0));
    send_frame(8'h96, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);

    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("overrun_total", 32'(ovr_cnt), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
